// File: rtl/wm_read_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : wm_read_arbiter_if
//  Description : Requester-side bus of the weight-memory read arbiter.
//                Carries the per-requester request level, burst base address
//                and burst length (packed, slice i for requester i), the
//                one-hot grant pulse and the return strobes/data.
//                  master : requester side (drives req/req_addr/req_len)
//                  slave  : arbiter side   (drives gnt/rvalid/rlast/rdata)
//  Revision    : 1.0 - initial release
// ============================================================================
interface wm_read_arbiter_if #(
    parameter int NUM_REQ              = 9,
    parameter int ADDRESS_SIZE_WMEMORY = 32,
    parameter int DATA_WIDTH_WMEMORY   = 64,
    parameter int LEN_WIDTH            = 8
) ();
    logic [NUM_REQ-1:0]                      req;
    logic [NUM_REQ*ADDRESS_SIZE_WMEMORY-1:0] req_addr;
    logic [NUM_REQ*LEN_WIDTH-1:0]            req_len;
    logic [NUM_REQ-1:0]                      gnt;
    logic [NUM_REQ-1:0]                      rvalid;
    logic                                    rlast;
    logic [DATA_WIDTH_WMEMORY-1:0]           rdata;

    modport master (
        output req, req_addr, req_len,
        input  gnt, rvalid, rlast, rdata
    );

    modport slave (
        input  req, req_addr, req_len,
        output gnt, rvalid, rlast, rdata
    );
endinterface
`default_nettype wire

// File: rtl/wm_read_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : wm_read_arbiter
//  Description : Shares the single weight-memory BRAM read port among
//                NUM_REQ requesters. Round-robin arbitration; each grant
//                issues a burst of consecutive word reads. In-flight reads
//                are tracked through the fixed BRAM latency and each returned
//                word is steered back to its owner with valid/last strobes.
//  Ports       : clk, reset   - clock, synchronous active-high reset
//                enable       - global stall (0 = no new grant, no beat issue)
//                bus          - requester bus (slave modport)
//                wm_ce/wm_we/wm_reset/wm_address/wm_dout - BRAM pins
//                busy         - burst active or reads in flight
//  Revision    : 1.0 - initial release
// ============================================================================
module wm_read_arbiter #(
    parameter int NUM_REQ              = 9,
    parameter int ADDRESS_SIZE_WMEMORY = 32,
    parameter int DATA_WIDTH_WMEMORY   = 64,
    parameter int LEN_WIDTH            = 8,
    parameter int RD_LATENCY           = 1
) (
    input  wire logic                            clk,
    input  wire logic                            reset,
    input  wire logic                            enable,
    wm_read_arbiter_if.slave                     bus,
    output logic                                 wm_ce,
    output logic                                 wm_we,
    output logic                                 wm_reset,
    output logic [ADDRESS_SIZE_WMEMORY-1:0]      wm_address,
    input  wire logic [DATA_WIDTH_WMEMORY-1:0]   wm_dout,
    output logic                                 busy
);

    localparam int c_IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    localparam logic [0:0] c_IDLE  = 1'b0;
    localparam logic [0:0] c_BURST = 1'b1;

    // Control state
    logic [0:0]                      r_state;
    logic [0:0]                      w_state_nxt;
    logic [c_IDX_W-1:0]              r_rr_ptr;
    logic [c_IDX_W-1:0]              r_id;
    logic [ADDRESS_SIZE_WMEMORY-1:0] r_base;
    logic [LEN_WIDTH-1:0]            r_len;
    logic [LEN_WIDTH-1:0]            r_beat;

    // Registered outputs
    logic [NUM_REQ-1:0]              r_gnt;
    logic                            r_wm_ce;
    logic [ADDRESS_SIZE_WMEMORY-1:0] r_wm_address;
    logic                            r_issue_last;

    // Arbitration result
    logic                            w_sel_found;
    logic [c_IDX_W-1:0]              w_sel_id;
    logic [NUM_REQ-1:0]              w_sel_onehot;
    logic [ADDRESS_SIZE_WMEMORY-1:0] w_sel_addr;
    logic [LEN_WIDTH-1:0]            w_sel_len;
    logic [NUM_REQ-1:0]              w_req_rot;

    // Next values produced by the output process
    logic                            w_grant;
    logic                            w_issue;
    logic                            w_issue_last;
    logic                            w_done;
    logic [ADDRESS_SIZE_WMEMORY-1:0] w_addr_nxt;

    // Return pipeline: one stage per BRAM latency clock
    logic [RD_LATENCY-1:0]           r_pipe_valid;
    logic [RD_LATENCY-1:0]           r_pipe_last;
    logic [c_IDX_W-1:0]              r_pipe_id [RD_LATENCY];

    // ------------------------------------------------------------------
    // Round-robin pick: rotate the request vector so bit 0 is rr_ptr,
    // take the first set bit, then map back to the absolute index.
    // ------------------------------------------------------------------
    always_comb begin : p_select
        int v_idx;
        v_idx        = 0;
        w_sel_found  = 1'b0;
        w_sel_id     = '0;
        w_req_rot    = NUM_REQ'({bus.req, bus.req} >> r_rr_ptr);
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!w_sel_found && w_req_rot[k]) begin
                v_idx = int'(r_rr_ptr) + k;
                if (v_idx >= NUM_REQ) begin
                    v_idx = v_idx - NUM_REQ;
                end
                w_sel_found = 1'b1;
                w_sel_id    = c_IDX_W'(v_idx);
            end
        end

        w_sel_onehot = '0;
        w_sel_addr   = '0;
        w_sel_len    = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_sel_id == c_IDX_W'(i)) begin
                w_sel_onehot[i] = 1'b1;
                w_sel_addr      = bus.req_addr[i*ADDRESS_SIZE_WMEMORY +: ADDRESS_SIZE_WMEMORY];
                w_sel_len       = bus.req_len[i*LEN_WIDTH +: LEN_WIDTH];
            end
        end
        // A zero length still means one word
        if (w_sel_len == '0) begin
            w_sel_len = LEN_WIDTH'(1);
        end
    end

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE: begin
                if (enable && w_sel_found) begin
                    w_state_nxt = c_BURST;
                end
            end
            c_BURST: begin
                if (enable && (r_beat >= r_len)) begin
                    w_state_nxt = c_IDLE;
                end
            end
            default: w_state_nxt = c_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs (next values of the registered BRAM-side signals)
    // ------------------------------------------------------------------
    always_comb begin
        w_grant      = 1'b0;
        w_issue      = 1'b0;
        w_issue_last = 1'b0;
        w_done       = 1'b0;
        w_addr_nxt   = r_wm_address;   // address holds whenever no beat issues
        case (r_state)
            c_IDLE: begin
                if (enable && w_sel_found) begin
                    // Beat 0 goes out on the grant edge itself
                    w_grant      = 1'b1;
                    w_issue      = 1'b1;
                    w_addr_nxt   = w_sel_addr;
                    w_issue_last = (w_sel_len == LEN_WIDTH'(1));
                end
            end
            c_BURST: begin
                if (enable) begin
                    if (r_beat < r_len) begin
                        w_issue      = 1'b1;
                        w_addr_nxt   = r_base + ADDRESS_SIZE_WMEMORY'(r_beat);
                        w_issue_last = ((r_beat + LEN_WIDTH'(1)) == r_len);
                    end else begin
                        w_done = 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // Burst bookkeeping and registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rr_ptr     <= '0;
            r_id         <= '0;
            r_base       <= '0;
            r_len        <= '0;
            r_beat       <= '0;
            r_gnt        <= '0;
            r_wm_ce      <= 1'b0;
            r_wm_address <= '0;
            r_issue_last <= 1'b0;
        end else begin
            r_wm_ce      <= w_issue;
            r_wm_address <= w_addr_nxt;
            r_issue_last <= w_issue_last;
            r_gnt        <= '0;
            if (w_grant) begin
                r_gnt  <= w_sel_onehot;
                r_id   <= w_sel_id;
                r_base <= w_sel_addr;
                r_len  <= w_sel_len;
                r_beat <= LEN_WIDTH'(1);
            end else if (w_issue) begin
                r_beat <= r_beat + LEN_WIDTH'(1);
            end
            if (w_done) begin
                r_rr_ptr <= (r_id == c_IDX_W'(NUM_REQ - 1)) ? '0 : r_id + c_IDX_W'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Return pipeline: follows the BRAM latency, never stalls.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pipe_valid <= '0;
            r_pipe_last  <= '0;
            for (int s = 0; s < RD_LATENCY; s++) begin
                r_pipe_id[s] <= '0;
            end
        end else begin
            r_pipe_valid[0] <= r_wm_ce;
            r_pipe_last[0]  <= r_issue_last;
            r_pipe_id[0]    <= r_id;
            for (int s = 1; s < RD_LATENCY; s++) begin
                r_pipe_valid[s] <= r_pipe_valid[s-1];
                r_pipe_last[s]  <= r_pipe_last[s-1];
                r_pipe_id[s]    <= r_pipe_id[s-1];
            end
        end
    end

    always_comb begin
        bus.rvalid = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (r_pipe_valid[RD_LATENCY-1] && (r_pipe_id[RD_LATENCY-1] == c_IDX_W'(i))) begin
                bus.rvalid[i] = 1'b1;
            end
        end
    end

    assign bus.gnt    = r_gnt;
    assign bus.rlast  = r_pipe_valid[RD_LATENCY-1] & r_pipe_last[RD_LATENCY-1];
    assign bus.rdata  = wm_dout;

    assign wm_ce      = r_wm_ce;
    assign wm_we      = 1'b0;
    assign wm_reset   = reset;
    assign wm_address = r_wm_address;
    assign busy       = (r_state == c_BURST) | (|r_pipe_valid);

endmodule
`default_nettype wire

// File: tb/tb_wm_read_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_wm_read_arbiter
//  Description : Directed self-checking bench. Two arbiter instances share
//                the same requester stimulus: one with RD_LATENCY=1 and one
//                with RD_LATENCY=3, each with its own BRAM model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_wm_read_arbiter;
    localparam int NR = 9;
    localparam int AW = 32;
    localparam int DW = 64;
    localparam int LW = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             reset;
    logic             enable;
    logic [NR-1:0]    req;
    logic [NR*AW-1:0] req_addr;
    logic [NR*LW-1:0] req_len;

    int n_chk  = 0;
    int n_fail = 0;

    wm_read_arbiter_if #(.NUM_REQ(NR), .ADDRESS_SIZE_WMEMORY(AW), .DATA_WIDTH_WMEMORY(DW), .LEN_WIDTH(LW)) bus1 ();
    wm_read_arbiter_if #(.NUM_REQ(NR), .ADDRESS_SIZE_WMEMORY(AW), .DATA_WIDTH_WMEMORY(DW), .LEN_WIDTH(LW)) bus3 ();

    assign bus1.req = req;  assign bus1.req_addr = req_addr;  assign bus1.req_len = req_len;
    assign bus3.req = req;  assign bus3.req_addr = req_addr;  assign bus3.req_len = req_len;

    logic          ce1, we1, wr1, busy1;
    logic [AW-1:0] addr1;
    logic [DW-1:0] dout1;
    logic          ce3, we3, wr3, busy3;
    logic [AW-1:0] addr3;
    logic [DW-1:0] dout3, st1, st2;

    wm_read_arbiter #(.NUM_REQ(NR), .ADDRESS_SIZE_WMEMORY(AW), .DATA_WIDTH_WMEMORY(DW),
                      .LEN_WIDTH(LW), .RD_LATENCY(1)) dut1 (
        .clk(clk), .reset(reset), .enable(enable), .bus(bus1),
        .wm_ce(ce1), .wm_we(we1), .wm_reset(wr1), .wm_address(addr1),
        .wm_dout(dout1), .busy(busy1));

    wm_read_arbiter #(.NUM_REQ(NR), .ADDRESS_SIZE_WMEMORY(AW), .DATA_WIDTH_WMEMORY(DW),
                      .LEN_WIDTH(LW), .RD_LATENCY(3)) dut3 (
        .clk(clk), .reset(reset), .enable(enable), .bus(bus3),
        .wm_ce(ce3), .wm_we(we3), .wm_reset(wr3), .wm_address(addr3),
        .wm_dout(dout3), .busy(busy3));

    // BRAM contents: a fixed function of the address
    function automatic logic [DW-1:0] mdata(input logic [AW-1:0] a);
        return {~a, a ^ 32'h5A5A_0000};
    endfunction

    always @(posedge clk) begin
        if (ce1) dout1 <= mdata(addr1);
        st1   <= mdata(addr3);
        st2   <= st1;
        dout3 <= st2;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int idx, input logic [AW-1:0] a, input logic [LW-1:0] l);
        req_addr[idx*AW +: AW] = a;
        req_len[idx*LW +: LW]  = l;
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset();
        reset = 1'b1; enable = 1'b1; req = '0; req_addr = '0; req_len = '0;
        tick(); tick();
        n_chk++; if (bus1.gnt !== 9'h000) begin n_fail++; $display("FAIL reset_gnt: got %h expected %h", bus1.gnt, 9'h000); end
        n_chk++; if (bus1.rvalid !== 9'h000) begin n_fail++; $display("FAIL reset_rvalid: got %h expected %h", bus1.rvalid, 9'h000); end
        n_chk++; if (bus1.rlast !== 1'b0) begin n_fail++; $display("FAIL reset_rlast: got %b expected 0", bus1.rlast); end
        n_chk++; if (ce1 !== 1'b0) begin n_fail++; $display("FAIL reset_ce: got %b expected 0", ce1); end
        n_chk++; if (addr1 !== 32'h0) begin n_fail++; $display("FAIL reset_addr: got %h expected 0", addr1); end
        n_chk++; if (busy1 !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy1); end
        n_chk++; if (we1 !== 1'b0) begin n_fail++; $display("FAIL reset_we: got %b expected 0", we1); end
        n_chk++; if (wr1 !== 1'b1) begin n_fail++; $display("FAIL reset_wm_reset: got %b expected 1", wr1); end
        reset = 1'b0;
        tick();
        n_chk++; if (wr1 !== 1'b0) begin n_fail++; $display("FAIL release_wm_reset: got %b expected 0", wr1); end
    endtask

    // ------------------------------------------------------------------
    task automatic test_single_burst();
        logic [NR-1:0] e_gnt, e_rv;
        set_req(2, 32'h100, 8'd3);
        req = 9'h004;
        for (int k = 1; k <= 5; k++) begin
            tick();
            e_gnt = (k == 1) ? 9'h004 : 9'h000;
            e_rv  = (k >= 2 && k <= 4) ? 9'h004 : 9'h000;
            n_chk++; if (bus1.gnt !== e_gnt) begin n_fail++; $display("FAIL single_gnt edge %0d: got %h expected %h", k, bus1.gnt, e_gnt); end
            n_chk++; if (ce1 !== (k <= 3)) begin n_fail++; $display("FAIL single_ce edge %0d: got %b expected %b", k, ce1, (k <= 3)); end
            if (k <= 3) begin
                n_chk++; if (addr1 !== 32'h100 + 32'(k - 1)) begin n_fail++; $display("FAIL single_addr edge %0d: got %h expected %h", k, addr1, 32'h100 + 32'(k - 1)); end
            end
            n_chk++; if (bus1.rvalid !== e_rv) begin n_fail++; $display("FAIL single_rvalid edge %0d: got %h expected %h", k, bus1.rvalid, e_rv); end
            n_chk++; if (bus1.rlast !== (k == 4)) begin n_fail++; $display("FAIL single_rlast edge %0d: got %b expected %b", k, bus1.rlast, (k == 4)); end
            if (e_rv != 0) begin
                n_chk++; if (bus1.rdata !== mdata(32'h100 + 32'(k - 2))) begin n_fail++; $display("FAIL single_rdata edge %0d: got %h expected %h", k, bus1.rdata, mdata(32'h100 + 32'(k - 2))); end
            end
            n_chk++; if (busy1 !== (k <= 4)) begin n_fail++; $display("FAIL single_busy edge %0d: got %b expected %b", k, busy1, (k <= 4)); end
            if (k == 1) req = '0;
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_round_robin();
        int id, pid;
        reset = 1'b1; tick(); reset = 1'b0;
        for (int i = 0; i < NR; i++) set_req(i, 32'h1000 + 32'(i * 16), 8'd1);
        req = 9'h111;
        pid = 0;
        for (int k = 1; k <= 12; k++) begin
            tick();
            id = (((k - 1) / 2) % 3) * 4;
            if (k % 2 == 1) begin
                n_chk++; if (bus1.gnt !== (9'h001 << id)) begin n_fail++; $display("FAIL rr_gnt edge %0d: got %h expected %h", k, bus1.gnt, 9'h001 << id); end
                n_chk++; if (addr1 !== 32'h1000 + 32'(id * 16) || ce1 !== 1'b1) begin n_fail++; $display("FAIL rr_issue edge %0d: got ce=%b addr=%h expected ce=1 addr=%h", k, ce1, addr1, 32'h1000 + 32'(id * 16)); end
                pid = id;
            end else begin
                n_chk++; if (bus1.gnt !== 9'h000) begin n_fail++; $display("FAIL rr_gap edge %0d: got %h expected 000", k, bus1.gnt); end
                n_chk++; if (bus1.rvalid !== (9'h001 << pid) || bus1.rlast !== 1'b1) begin n_fail++; $display("FAIL rr_return edge %0d: got rvalid=%h rlast=%b expected rvalid=%h rlast=1", k, bus1.rvalid, bus1.rlast, 9'h001 << pid); end
                n_chk++; if (bus1.rdata !== mdata(32'h1000 + 32'(pid * 16))) begin n_fail++; $display("FAIL rr_rdata edge %0d: got %h expected %h", k, bus1.rdata, mdata(32'h1000 + 32'(pid * 16))); end
            end
        end
        req = '0;
        tick(); tick();
    endtask

    // ------------------------------------------------------------------
    task automatic test_len_zero();
        int n_ce, n_rv;
        n_ce = 0; n_rv = 0;
        set_req(5, 32'h7F0, 8'd0);
        req = 9'h020;
        for (int k = 1; k <= 6; k++) begin
            tick();
            if (ce1) n_ce++;
            if (bus1.rvalid != 0) n_rv++;
            if (k == 1) begin
                req = '0;
                n_chk++; if (bus1.gnt !== 9'h020) begin n_fail++; $display("FAIL len0_gnt: got %h expected 020", bus1.gnt); end
            end
            if (k == 2) begin
                n_chk++; if (bus1.rvalid !== 9'h020 || bus1.rlast !== 1'b1) begin n_fail++; $display("FAIL len0_return: got rvalid=%h rlast=%b expected rvalid=020 rlast=1", bus1.rvalid, bus1.rlast); end
                n_chk++; if (bus1.rdata !== mdata(32'h7F0)) begin n_fail++; $display("FAIL len0_rdata: got %h expected %h", bus1.rdata, mdata(32'h7F0)); end
            end
        end
        n_chk++; if (n_ce !== 1) begin n_fail++; $display("FAIL len0_reads: got %0d expected 1", n_ce); end
        n_chk++; if (n_rv !== 1) begin n_fail++; $display("FAIL len0_returns: got %0d expected 1", n_rv); end
    endtask

    // ------------------------------------------------------------------
    task automatic test_stall();
        logic          e_ce, e_rvb;
        logic [AW-1:0] e_addr, e_raddr;
        set_req(1, 32'h300, 8'd4);
        req = 9'h002;
        for (int k = 1; k <= 9; k++) begin
            tick();
            e_ce    = (k == 1 || k == 2 || k == 6 || k == 7);
            e_addr  = (k <= 2) ? 32'h300 + 32'(k - 1) : (k <= 5) ? 32'h301 : 32'h300 + 32'(k - 4);
            e_rvb   = (k == 2 || k == 3 || k == 7 || k == 8);
            e_raddr = (k <= 3) ? 32'h300 + 32'(k - 2) : 32'h300 + 32'(k - 5);
            n_chk++; if (ce1 !== e_ce) begin n_fail++; $display("FAIL stall_ce edge %0d: got %b expected %b", k, ce1, e_ce); end
            if (k <= 7) begin
                n_chk++; if (addr1 !== e_addr) begin n_fail++; $display("FAIL stall_addr edge %0d: got %h expected %h", k, addr1, e_addr); end
            end
            n_chk++; if (bus1.rvalid !== (e_rvb ? 9'h002 : 9'h000)) begin n_fail++; $display("FAIL stall_rvalid edge %0d: got %h expected %h", k, bus1.rvalid, e_rvb ? 9'h002 : 9'h000); end
            if (e_rvb) begin
                n_chk++; if (bus1.rdata !== mdata(e_raddr)) begin n_fail++; $display("FAIL stall_rdata edge %0d: got %h expected %h", k, bus1.rdata, mdata(e_raddr)); end
            end
            n_chk++; if (bus1.rlast !== (k == 8)) begin n_fail++; $display("FAIL stall_rlast edge %0d: got %b expected %b", k, bus1.rlast, (k == 8)); end
            n_chk++; if (busy1 !== (k <= 8)) begin n_fail++; $display("FAIL stall_busy edge %0d: got %b expected %b", k, busy1, (k <= 8)); end
            if (k == 1) req = '0;
            if (k == 2) enable = 1'b0;
            if (k == 5) enable = 1'b1;
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_back_to_back();
        int            iss_k [5];
        int            iss_id[5];
        logic [AW-1:0] iss_a [5];
        logic          iss_l [5];
        logic [NR-1:0] e_rv, e_gnt;
        logic          e_last, e_ce;
        logic [AW-1:0] e_a, e_ra;
        iss_k  = '{1, 2, 4, 5, 6};
        iss_id = '{1, 1, 3, 3, 3};
        iss_a  = '{32'h400, 32'h401, 32'h500, 32'h501, 32'h502};
        iss_l  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        reset = 1'b1; tick(); reset = 1'b0;
        set_req(1, 32'h400, 8'd2);
        set_req(3, 32'h500, 8'd3);
        req = 9'h00A;
        for (int k = 1; k <= 11; k++) begin
            tick();
            e_rv = '0; e_last = 1'b0; e_ce = 1'b0; e_a = '0; e_ra = '0;
            for (int j = 0; j < 5; j++) begin
                if (iss_k[j] == k) begin e_ce = 1'b1; e_a = iss_a[j]; end
                if (iss_k[j] + 3 == k) begin e_rv = 9'h001 << iss_id[j]; e_last = iss_l[j]; e_ra = iss_a[j]; end
            end
            e_gnt = (k == 1) ? 9'h002 : (k == 4) ? 9'h008 : 9'h000;
            n_chk++; if (bus3.gnt !== e_gnt) begin n_fail++; $display("FAIL b2b_gnt edge %0d: got %h expected %h", k, bus3.gnt, e_gnt); end
            n_chk++; if (ce3 !== e_ce) begin n_fail++; $display("FAIL b2b_ce edge %0d: got %b expected %b", k, ce3, e_ce); end
            if (e_ce) begin
                n_chk++; if (addr3 !== e_a) begin n_fail++; $display("FAIL b2b_addr edge %0d: got %h expected %h", k, addr3, e_a); end
            end
            n_chk++; if (bus3.rvalid !== e_rv) begin n_fail++; $display("FAIL b2b_rvalid edge %0d: got %h expected %h", k, bus3.rvalid, e_rv); end
            n_chk++; if (bus3.rlast !== e_last) begin n_fail++; $display("FAIL b2b_rlast edge %0d: got %b expected %b", k, bus3.rlast, e_last); end
            if (e_rv != 0) begin
                n_chk++; if (bus3.rdata !== mdata(e_ra)) begin n_fail++; $display("FAIL b2b_rdata edge %0d: got %h expected %h", k, bus3.rdata, mdata(e_ra)); end
            end
            n_chk++; if (busy3 !== (k <= 9)) begin n_fail++; $display("FAIL b2b_busy edge %0d: got %b expected %b", k, busy3, (k <= 9)); end
            if (k == 1) req = 9'h008;
            if (k == 4) req = '0;
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset_mid_burst();
        set_req(7, 32'h600, 8'd5);
        set_req(0, 32'h6F0, 8'd1);
        req = 9'h080;
        for (int k = 1; k <= 3; k++) begin
            tick();
            if (k == 1) req = '0;
        end
        n_chk++; if (ce1 !== 1'b1 || addr1 !== 32'h602) begin n_fail++; $display("FAIL midrst_beat2: got ce=%b addr=%h expected ce=1 addr=602", ce1, addr1); end
        req = 9'h081;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        n_chk++; if (ce1 !== 1'b0 || ce3 !== 1'b0) begin n_fail++; $display("FAIL midrst_ce: got %b/%b expected 0/0", ce1, ce3); end
        n_chk++; if (bus1.rvalid !== 9'h000 || bus3.rvalid !== 9'h000) begin n_fail++; $display("FAIL midrst_rvalid: got %h/%h expected 000/000", bus1.rvalid, bus3.rvalid); end
        n_chk++; if (busy1 !== 1'b0 || busy3 !== 1'b0) begin n_fail++; $display("FAIL midrst_busy: got %b/%b expected 0/0", busy1, busy3); end
        tick();
        n_chk++; if (bus1.gnt !== 9'h001 || bus3.gnt !== 9'h001) begin n_fail++; $display("FAIL midrst_next_gnt: got %h/%h expected 001/001", bus1.gnt, bus3.gnt); end
        n_chk++; if (bus1.rvalid !== 9'h000) begin n_fail++; $display("FAIL midrst_rvalid1_after: got %h expected 000", bus1.rvalid); end
        req = 9'h080;
        for (int k = 6; k <= 7; k++) begin
            tick();
            n_chk++; if (bus3.rvalid !== 9'h000) begin n_fail++; $display("FAIL midrst_rvalid3 edge %0d: got %h expected 000", k, bus3.rvalid); end
        end
        n_chk++; if (bus1.gnt !== 9'h080) begin n_fail++; $display("FAIL midrst_gnt7: got %h expected 080", bus1.gnt); end
        req = '0;
        for (int k = 0; k < 12; k++) tick();
        n_chk++; if (busy1 !== 1'b0 || busy3 !== 1'b0) begin n_fail++; $display("FAIL midrst_drain_busy: got %b/%b expected 0/0", busy1, busy3); end
    endtask

    initial begin
        test_reset();
        test_single_burst();
        test_round_robin();
        test_len_zero();
        test_stall();
        test_back_to_back();
        test_reset_mid_burst();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
